// File: rtl/dbus_req_ctrl.sv
// rtl/dbus_req_ctrl.sv - MEM-stage data-bus request controller for an SRAM-like req/addr_ok/data_ok bus
module dbus_req_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                dreq_valid,
    input  logic                dreq_write,
    input  logic [1:0]          dreq_size,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    input  logic                dreq_flush,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   dresp_rdata,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic [CNT_W-1:0]    stall_cycles
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e                state_q, state_d;
    logic                  discard_q, discard_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W/8-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [CNT_W-1:0]      stall_q, stall_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        data_req  = 1'b0;
        d_data_ok = 1'b0;
        case (state_q)
            IDLE: begin
                d_data_ok = ~dreq_valid;
                if (dreq_valid && !dreq_flush) begin
                    wr_d    = dreq_write;
                    size_d  = dreq_size;
                    addr_d  = dreq_addr;
                    strb_d  = dreq_strobe;
                    wdata_d = dreq_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A flush cannot withdraw req; the transaction runs to completion and is dropped.
                data_req = 1'b1;
                if (dreq_flush) discard_d = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        rdata_d = data_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (dreq_flush) discard_d = 1'b1;
                if (data_data_ok) begin
                    rdata_d = data_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                d_data_ok = discard_q ? ~dreq_valid : 1'b1;
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall_d = stall_q + {{(CNT_W-1){1'b0}}, ~d_data_ok};
    end

    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wstrb   = strb_q;
    assign data_wdata   = wdata_q;
    assign dresp_rdata  = rdata_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// tb/tb_dbus_req_ctrl.sv - randomized self-checking bench for dbus_req_ctrl
module tb_dbus_req_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          dreq_valid, dreq_write, dreq_flush;
    logic [1:0]    dreq_size;
    logic [AW-1:0] dreq_addr;
    logic [DW/8-1:0] dreq_strobe;
    logic [DW-1:0] dreq_wdata;
    logic          d_data_ok;
    logic [DW-1:0] dresp_rdata;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW/8-1:0] data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic [CW-1:0] stall_cycles;

    dbus_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_size(dreq_size),
        .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
        .dreq_flush(dreq_flush), .d_data_ok(d_data_ok), .dresp_rdata(dresp_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stall_m = 0;
    logic [DW-1:0] last_rd = '0;
    bit have_rd = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Common per-cycle checks; the stall model counts cycles whose expected ok is low.
    task automatic cyc_chk(input bit exp_ok, input bit exp_req);
        chk("d_data_ok", d_data_ok, exp_ok);
        chk("data_req", data_req, exp_req);
        chk("stall_cycles", stall_cycles, stall_m);
        if (!exp_ok) stall_m++;
    endtask

    // One request: addr_ok after aw extra ADDR cycles, data_ok bw cycles later (0 = same cycle).
    task automatic run_txn(input int aw, input int bw, input int fl_at);
        logic            wr;
        logic [1:0]      sz;
        logic [AW-1:0]   ad;
        logic [DW/8-1:0] st;
        logic [DW-1:0]   wd, rd;
        int  done_c;
        bit  flushed;
        bit  exp_ok, exp_req;
        wr = 1'($urandom); sz = 2'($urandom_range(0, 2)); ad = $urandom;
        st = 4'($urandom); wd = $urandom; rd = $urandom;
        done_c = aw + 2 + bw;
        flushed = 1'b0;
        for (int c = 0; c <= done_c; c++) begin
            @(negedge clk);
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom; dreq_flush = 1'b0;
            dreq_valid = 1'b1;
            if (c == 0) begin
                dreq_write = wr; dreq_size = sz; dreq_addr = ad; dreq_strobe = st; dreq_wdata = wd;
            end else begin
                dreq_write = 1'($urandom); dreq_size = 2'($urandom); dreq_addr = $urandom;
                dreq_strobe = 4'($urandom); dreq_wdata = $urandom;
            end
            if (c == fl_at) begin dreq_flush = 1'b1; flushed = 1'b1; end
            if (c == aw + 1) begin
                data_addr_ok = 1'b1;
                if (bw == 0) begin data_data_ok = 1'b1; data_rdata = rd; end
            end
            if (bw > 0 && c == aw + 1 + bw) begin data_data_ok = 1'b1; data_rdata = rd; end
            if (c == done_c) begin
                if (flushed) dreq_valid = 1'($urandom);
                data_data_ok = 1'($urandom);
            end
            #1;
            exp_ok  = (c == done_c) ? (flushed ? !dreq_valid : 1'b1) : 1'b0;
            exp_req = (c >= 1 && c <= aw + 1);
            cyc_chk(exp_ok, exp_req);
            if (exp_req) begin
                chk("bus_wr", data_wr, wr);
                chk("bus_size", data_size, sz);
                chk("bus_addr", data_addr, ad);
                chk("bus_wstrb", data_wstrb, st);
                chk("bus_wdata", data_wdata, wd);
            end
            if (c == done_c && !flushed) chk("dresp_rdata", dresp_rdata, rd);
        end
        last_rd = rd;
        have_rd = !flushed;
    endtask

    // IDLE cycle, optionally with a flushed request; a stray data_ok must be ignored.
    task automatic idle_cycle(input bit flush_req);
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'($urandom); data_rdata = $urandom;
        dreq_valid = flush_req; dreq_flush = flush_req; dreq_addr = $urandom;
        #1;
        cyc_chk(!flush_req, 1'b0);
        if (have_rd) chk("held_rdata", dresp_rdata, last_rd);
    endtask

    initial begin
        int aw, bw, fl, dc;
        resetn = 1'b0; dreq_valid = 1'b0; dreq_write = 1'b0; dreq_size = '0; dreq_addr = '0;
        dreq_strobe = '0; dreq_wdata = '0; dreq_flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        #12;
        chk("rst_req", data_req, 1'b0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_ok", d_data_ok, 1'b1);
        chk("rst_rdata", dresp_rdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_txn(0, 0, -1);
        chk("zero_wait_stall", stall_cycles, 2);
        run_txn(3, 2, -1);
        run_txn(0, 1, -1);
        idle_cycle(1'b0);
        run_txn(1, 3, 3);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        run_txn(2, 0, 1);

        for (int i = 0; i < 200; i++) begin
            aw = $urandom_range(0, 4);
            bw = $urandom_range(0, 4);
            dc = aw + 2 + bw;
            fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, dc - 1) : -1;
            run_txn(aw, bw, fl);
            case ($urandom_range(0, 3))
                0: idle_cycle(1'b0);
                1: idle_cycle(1'b1);
                default: ;
            endcase
        end

        // Asynchronous reset while a request is sitting in ADDR.
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0; dreq_flush = 1'b0; dreq_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_rst_req", data_req, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_req", data_req, 1'b0);
        chk("arst_stall", stall_cycles, 0);
        chk("arst_ok_valid", d_data_ok, 1'b0);
        dreq_valid = 1'b0;
        #1;
        chk("arst_ok_idle", d_data_ok, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        stall_m = 0; last_rd = '0; have_rd = 1'b1;
        idle_cycle(1'b0);
        run_txn(1, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbus_req_ctrl.md
Name: dbus_req_ctrl

Overview:
- Memory-stage data-bus responder.
- Accepts the MEM-stage load/store request, runs it on the SRAM-like data bus (req/addr_ok/data_ok), and returns read data.
- Produces the `d_data_ok` handshake that the hazard unit consumes to generate stallF/D/E/M and flushW.
- Sits between the MEM stage and the data-side bus/cache port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes = DATA_W/8)
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- dreq_valid  in  1  MEM stage has a load/store this cycle
- dreq_write  in  1  1 = store
- dreq_size  in  2  0 = byte, 1 = half, 2 = word
- dreq_addr  in  ADDR_W  byte address
- dreq_strobe  in  DATA_W/8  store byte enables
- dreq_wdata  in  DATA_W  store data
- dreq_flush  in  1  discard the in-flight request (exception/flush)
- d_data_ok  out  1  to hazard unit; 0 = MEM must stall
- dresp_rdata  out  DATA_W  load data, valid while d_data_ok in DONE
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  ADDR_W  bus address
- data_wstrb  out  DATA_W/8  bus strobes
- data_wdata  out  DATA_W  bus write data
- data_addr_ok  in  1  bus accepted address
- data_data_ok  in  1  bus completed; rdata valid
- data_rdata  in  DATA_W  bus read data
- stall_cycles  out  CNT_W  count of cycles with d_data_ok = 0

Behaviour:
- Reset (resetn = 0, async): state IDLE, discard flag 0, latched request 0, dresp_rdata 0, stall_cycles 0, data_req 0. Outputs are then combinational from state: d_data_ok = ~dreq_valid.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - d_data_ok = ~dreq_valid.
  - data_req = 0.
  - If dreq_valid and ~dreq_flush: latch write/size/addr/strobe/wdata and go to ADDR.
  - If dreq_valid and dreq_flush: stay in IDLE, nothing issued.
- ADDR:
  - data_req = 1; all bus fields driven from latched registers and held stable until addr_ok.
  - data_req is never withdrawn, even on flush.
  - addr_ok & data_ok in the same cycle: capture rdata and go to DONE.
  - addr_ok only: go to DATA.
  - Otherwise stay in ADDR.
  - d_data_ok = 0.
- DATA:
  - data_req = 0.
  - On data_ok: capture data_rdata into dresp_rdata and go to DONE.
  - d_data_ok = 0.
- DONE:
  - If the discard flag is 0: d_data_ok = 1 for exactly this cycle, and dresp_rdata is held.
  - If the discard flag is 1: d_data_ok = ~dreq_valid, as in IDLE.
  - Next state is IDLE; the discard flag clears.
  - The MEM stage advances on this cycle, so the same request is never reissued.
- Flush:
  - dreq_flush seen in ADDR or DATA sets the discard flag.
  - The bus transaction still completes (protocol compliance).
  - After completion the result is dropped.
- Stores: dresp_rdata is still loaded from data_rdata (don't-care to consumer).
- Latency with a zero-wait bus (addr_ok and data_ok same cycle as req): request seen in IDLE at cycle N, ADDR at N+1, DONE at N+2. d_data_ok is low at N and N+1, high at N+2.
- stall_cycles increments by 1 every cycle d_data_ok = 0 and wraps modulo 2^CNT_W.
- Stray data_ok in IDLE/DONE is ignored and never captured.
- Reset mid-transaction returns to IDLE immediately. The bus side is also reset by the same resetn.

Test Plan:
- Zero-wait load: addr 0x0000_0010, size 2; bus returns addr_ok & data_ok at first req cycle with rdata 0xDEADBEEF → d_data_ok 0,0,1; dresp_rdata = 0xDEADBEEF in DONE; stall_cycles = 2.
- Slow store: addr 0x100, strobe 4'b0011, wdata 0x1234; addr_ok after 3 cycles, data_ok 2 cycles later → data_req high exactly 4 cycles with stable fields; d_data_ok low 7 cycles then one high cycle.
- Back-to-back: new dreq_valid on the cycle after DONE → IDLE shows d_data_ok = 0 immediately; second transaction issues; no duplicate req for the first.
- Flush in DATA: load in progress, pulse dreq_flush → data_req not reasserted; after data_ok, DONE yields d_data_ok = ~dreq_valid (no ok pulse for the flushed load); returns to IDLE.
- Flush in IDLE with dreq_valid = 1 → no data_req ever; state stays IDLE.
- Async reset while in ADDR → data_req drops to 0 without a clock edge; stall_cycles = 0; d_data_ok = ~dreq_valid.
